nios_bts_local_responder: RTL and testbench
===========================================

# nios_bts_local_responder

Controller-side responder for the DDR2 local interface driven by the board-test-system memory port. It emulates init, `local_ready` flow control, the write-data request handshake and fixed-latency read return, backed by a small byte-enabled on-chip RAM. It sits in place of the DDR2 controller for loopback and self-test builds, so the BTS memory port runs end to end without external memory.

## Interface
- `local_addr_width`, 23: request address width; only the low `mem_widthad` bits index the RAM.
- `local_data_width`, 160: data beat width.
- `local_be_width`, 20: byte enables, `local_data_width/8`.
- `local_size_width`, 1: burst size field width.
- `local_size_max`, 1: largest legal burst, in beats.
- `mem_widthad`, 8: RAM depth is 2^`mem_widthad` beats.
- `init_cycles`, 64: cycles from reset release to `local_init_done`; must be ≥ 1.
- `read_latency`, 4: cycles from read acceptance to first `local_rdata_valid`; must be ≥ 2.

Ports:
- `local_clk` in 1: the only clock. All logic is rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `local_addr` in `local_addr_width`: beat address.
- `local_be` in `local_be_width`: byte enables, sampled with `local_wdata`.
- `local_read_req` in 1: read request.
- `local_write_req` in 1: write request.
- `local_size` in `local_size_width`: burst length in beats.
- `local_burst_begin` in 1: first-beat marker. Checked only, see below.
- `local_wdata` in `local_data_width`: write data.
- `ready_throttle` in 1: when high, forces `local_ready` low. Used for backpressure tests.
- `local_ready` out 1: a request is accepted on a cycle where a request and `local_ready` are both high.
- `local_wdata_req` out 1: requests one write beat, which is sampled on the following cycle.
- `local_rdata` out `local_data_width`: read data.
- `local_rdata_valid` out 1: read beat valid.
- `local_init_done` out 1: initialisation complete.
- `protocol_error` out 1: sticky error flag, cleared only by reset.

## Operation
- States are INIT, IDLE, WRITE and RDISSUE.
- **INIT**
  - Counts `init_cycles`, then sets `local_init_done` and moves to IDLE.
  - `local_ready` is low throughout INIT.
- **IDLE**
  - `local_ready` = `~ready_throttle`.
  - Accepting a write latches the address and effective size, then moves to WRITE.
  - Accepting a read inserts beat 0 into the read pipeline. If the effective size is greater than 1, it moves to RDISSUE; otherwise it stays in IDLE.
- **Effective size**
  - Equals `local_size`.
  - A size of 0, or a size above `local_size_max`, gives effective size 1 and sets `protocol_error`.
- **Simultaneous read and write request**: the write is accepted, the read is dropped, and `protocol_error` is set.
- **`local_burst_begin`**: if it is low on an accepted request, `protocol_error` is set. The request is still served.
- **WRITE**
  - `local_wdata_req` is high for exactly size cycles, starting the cycle after acceptance.
  - Each beat is sampled one cycle after its request and written with `local_be` applied per byte lane.
  - The address increments per beat, modulo 2^`mem_widthad`.
  - Returns to IDLE on the cycle after the last data beat is sampled. `local_ready` is low throughout WRITE.
- **RDISSUE**
  - Inserts one beat per cycle, with incrementing and wrapping address, until size beats are issued.
  - `local_ready` is low throughout RDISSUE. Returns to IDLE after the last beat.
- **Read pipeline**
  - A shift line of depth `read_latency` carries the valid bit and address.
  - A RAM read starts at stage `read_latency-1`; the registered output drives `local_rdata`.
  - Back-to-back single-beat reads are accepted every cycle.
- **Read-after-write**: a read accepted after a write returns the new data, because the write completes before `local_ready` rises.
- **Read of an unwritten address**: returns RAM contents. Benches write an address before reading it.

## Timing
- **Reset values**
  - `local_ready`, `local_wdata_req`, `local_rdata_valid`, `local_init_done` and `protocol_error` reset to 0.
  - `local_rdata` resets to 0.
  - State resets to INIT.
- **Reset mid-operation**
  - Aborts any burst, flushes the read pipeline (no further valid beats) and restarts INIT.
  - RAM contents are not cleared.
- **Init**: `local_init_done` rises exactly `init_cycles` cycles after `reset` is released.
- **Read latency**: a read accepted at cycle T gives `local_rdata_valid` at T+`read_latency`. A burst returns size consecutive valid beats.
- **Write handshake**: for a write accepted at T, `local_wdata_req` is high for cycles T+1 … T+size. Data is sampled at T+2 … T+size+1.
- **Throttle**: `ready_throttle` takes effect combinationally in IDLE. It never stalls an accepted burst.

## Structure
- Shared package `nios_bts_mem_pkg` holds:
  - the state encoding (INIT, IDLE, WRITE, RDISSUE);
  - the `local_data_width/8` lane constant;
  - the effective-size function.
- One sub-module, `nios_bts_local_resp_ram`: simple dual-port, byte-enabled, registered-output RAM, 2^`mem_widthad` × `local_data_width`.
- The top level holds the FSM, counters, read pipeline and error logic.

## Test plan
- **Init timing**: release `reset` at cycle 0 → `local_init_done` and `local_ready` go high at cycle 64. No `local_ready` before that.
- **Single write then read**:
  - Stimulus: write addr 0x10, data 0x0123…, `local_be`=all ones; then read addr 0x10 accepted at T.
  - Required: `local_wdata_req` is one cycle long; `local_rdata_valid` occurs at T+4 with the written data.
- **Byte enables**:
  - Stimulus: write all-ones to addr 5; write zeros to addr 5 with `local_be`=20'h00001; read addr 5.
  - Required: data is all-ones except byte 0, which is 0x00.
- **Wrap and back-to-back reads**:
  - Stimulus: with `local_size_max`=2, write a size-2 burst to addr 0xFF; then issue four single-beat reads (0xFF, 0x00, 0xFF, 0x00) on consecutive cycles.
  - Required: four consecutive valid beats with the matching data.
- **Protocol errors**: read and write requested together, size 0, or `local_burst_begin` low → only the write is served, and `protocol_error` goes high and stays high until reset.
- **Reset during a burst**: assert `reset` with two read beats in flight → no further `local_rdata_valid`, INIT restarts, and previously written data reads back intact afterwards.

Source files
------------

// File: rtl/nios_bts_mem_pkg.sv
// Shared definitions for the BTS local-interface responder: FSM encoding,
// byte-lane count and burst-size legalisation.
package nios_bts_mem_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_RDISSUE
  } state_t;

  localparam int unsigned DATA_W = 160;
  localparam int unsigned LANES  = DATA_W / 8;

  typedef struct packed {
    logic [7:0] beats;
    logic       err;
  } eff_size_t;

  // Illegal sizes (zero or above the maximum) are served as one beat and flagged.
  function automatic eff_size_t eff_size(input logic [7:0] size, input logic [7:0] size_max);
    eff_size_t r;
    r.beats = size;
    r.err   = 1'b0;
    if (size == 8'd0 || size > size_max) begin
      r.beats = 8'd1;
      r.err   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_bts_local_resp_ram.sv
// Simple dual-port RAM with per-byte write enables and a registered read port.
module nios_bts_local_resp_ram #(
  parameter int unsigned mem_widthad = 8,
  parameter int unsigned data_width  = 160,
  parameter int unsigned be_width    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [mem_widthad-1:0] waddr,
  input  logic [data_width-1:0]  wdata,
  input  logic [be_width-1:0]    be,
  input  logic                   re,
  input  logic [mem_widthad-1:0] raddr,
  output logic [data_width-1:0]  rdata
);

  logic [data_width-1:0] mem [2**mem_widthad];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(be_width); i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nios_bts_local_responder.sv
// DDR2 local-interface stand-in: init delay, ready/wdata_req handshakes and a
// fixed-latency read pipeline over an on-chip RAM.
module nios_bts_local_responder
  import nios_bts_mem_pkg::*;
#(
  parameter int unsigned local_addr_width = 23,
  parameter int unsigned local_data_width = DATA_W,
  parameter int unsigned local_be_width   = LANES,
  parameter int unsigned local_size_width = 1,
  parameter int unsigned local_size_max   = 1,
  parameter int unsigned mem_widthad      = 8,
  parameter int unsigned init_cycles      = 64,
  parameter int unsigned read_latency     = 4
) (
  input  logic                        local_clk,
  input  logic                        reset,
  input  logic [local_addr_width-1:0] local_addr,
  input  logic [local_be_width-1:0]   local_be,
  input  logic                        local_read_req,
  input  logic                        local_write_req,
  input  logic [local_size_width-1:0] local_size,
  input  logic                        local_burst_begin,
  input  logic [local_data_width-1:0] local_wdata,
  input  logic                        ready_throttle,
  output logic                        local_ready,
  output logic                        local_wdata_req,
  output logic [local_data_width-1:0] local_rdata,
  output logic                        local_rdata_valid,
  output logic                        local_init_done,
  output logic                        protocol_error
);

  localparam int unsigned PIPE_D = read_latency - 1;
  localparam int unsigned INIT_W = (init_cycles > 1) ? $clog2(init_cycles) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(init_cycles - 1);

  state_t                 state_q, state_d;
  logic [INIT_W-1:0]      init_cnt;
  logic [7:0]             burst_len, req_cnt, beat_cnt;
  logic [mem_widthad-1:0] cur_addr, req_addr, ins_addr;
  logic                   ins_vld, accept, wbeat_p0;
  logic [PIPE_D-1:0]      rd_vld_p;
  logic [mem_widthad-1:0] rd_addr_p [PIPE_D];
  eff_size_t              eff;
  logic                   unused_addr_hi;

  assign req_addr        = local_addr[mem_widthad-1:0];
  assign unused_addr_hi  = ^local_addr[local_addr_width-1:mem_widthad];
  assign eff             = eff_size(8'(local_size), 8'(local_size_max));
  assign local_ready     = (state_q == ST_IDLE) && !ready_throttle;
  assign accept          = local_ready && (local_read_req || local_write_req);
  assign local_wdata_req = (state_q == ST_WRITE) && (req_cnt != burst_len);

  always_comb begin
    state_d  = state_q;
    ins_vld  = 1'b0;
    ins_addr = cur_addr;
    case (state_q)
      ST_INIT: if (init_cnt == INIT_LAST) state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          // A write wins over a simultaneous read; the read is dropped.
          if (local_write_req) begin
            state_d = ST_WRITE;
          end else begin
            ins_vld  = 1'b1;
            ins_addr = req_addr;
            if (eff.beats > 8'd1) state_d = ST_RDISSUE;
          end
        end
      end
      ST_WRITE: if (wbeat_p0 && beat_cnt == burst_len - 8'd1) state_d = ST_IDLE;
      ST_RDISSUE: begin
        ins_vld = 1'b1;
        if (req_cnt == burst_len - 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge local_clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_INIT;
      init_cnt          <= '0;
      local_init_done   <= 1'b0;
      protocol_error    <= 1'b0;
      wbeat_p0          <= 1'b0;
      burst_len         <= 8'd1;
      req_cnt           <= '0;
      beat_cnt          <= '0;
      cur_addr          <= '0;
      rd_vld_p          <= '0;
      local_rdata_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      wbeat_p0 <= local_wdata_req;
      if (state_q == ST_INIT) begin
        if (init_cnt == INIT_LAST) local_init_done <= 1'b1;
        else init_cnt <= init_cnt + 1'b1;
      end
      if (accept && (eff.err || !local_burst_begin || (local_read_req && local_write_req)))
        protocol_error <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            burst_len <= eff.beats;
            beat_cnt  <= '0;
            if (local_write_req) begin
              req_cnt  <= '0;
              cur_addr <= req_addr;
            end else begin
              req_cnt  <= 8'd1;
              cur_addr <= req_addr + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (local_wdata_req) req_cnt <= req_cnt + 8'd1;
          if (wbeat_p0) begin
            beat_cnt <= beat_cnt + 8'd1;
            cur_addr <= cur_addr + 1'b1;
          end
        end
        ST_RDISSUE: begin
          req_cnt  <= req_cnt + 8'd1;
          cur_addr <= cur_addr + 1'b1;
        end
        default: ;
      endcase
      rd_vld_p[0] <= ins_vld;
      for (int i = 1; i < int'(PIPE_D); i++) rd_vld_p[i] <= rd_vld_p[i-1];
      local_rdata_valid <= rd_vld_p[PIPE_D-1];
    end
  end

  // Read pipeline stage boundary: address follows its valid bit, RAM read in the last stage.
  always_ff @(posedge local_clk) begin
    rd_addr_p[0] <= ins_addr;
    for (int i = 1; i < int'(PIPE_D); i++) rd_addr_p[i] <= rd_addr_p[i-1];
  end

  nios_bts_local_resp_ram #(
    .mem_widthad(mem_widthad),
    .data_width (local_data_width),
    .be_width   (local_be_width)
  ) u_ram (
    .clk  (local_clk),
    .rst  (reset),
    .we   (wbeat_p0),
    .waddr(cur_addr),
    .wdata(local_wdata),
    .be   (local_be),
    .re   (rd_vld_p[PIPE_D-1]),
    .raddr(rd_addr_p[PIPE_D-1]),
    .rdata(local_rdata)
  );

endmodule

// File: tb/tb_nios_bts_local_responder.sv
// Bench for nios_bts_local_responder: vector table plus hand sequences, reads
// checked through a timed scoreboard.
module tb_nios_bts_local_responder;

  localparam logic [159:0] D0     = 160'h0123456789abcdef0123456789abcdef01234567;
  localparam logic [159:0] ONES   = {160{1'b1}};
  localparam logic [159:0] BE_EXP = {{152{1'b1}}, 8'h00};
  localparam logic [159:0] DA     = 160'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3;
  localparam logic [159:0] DB     = 160'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3;
  localparam logic [159:0] DC     = 160'hc0ffee;
  localparam logic [159:0] DE     = 160'hbeef;
  localparam logic [159:0] DF     = 160'hfeed;
  localparam logic [19:0]  BE_ALL = 20'hfffff;

  logic         local_clk = 1'b0;
  logic         reset;
  logic [22:0]  local_addr;
  logic [19:0]  local_be;
  logic         local_read_req, local_write_req;
  logic [1:0]   local_size;
  logic         local_burst_begin;
  logic [159:0] local_wdata;
  logic         ready_throttle;
  logic         local_ready, local_wdata_req, local_rdata_valid, local_init_done, protocol_error;
  logic [159:0] local_rdata;

  int pass = 0;
  int total = 0;
  int cyc = 0;

  typedef struct {
    logic [159:0] data;
    int           due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit           wr;
    logic [7:0]   addr;
    int           size;
    logic [19:0]  be;
    logic [159:0] d0, d1;
    logic [159:0] x0, x1;
  } vec_t;
  vec_t vt [7];

  nios_bts_local_responder #(
    .local_size_width(2),
    .local_size_max  (2)
  ) dut (
    .local_clk        (local_clk),
    .reset            (reset),
    .local_addr       (local_addr),
    .local_be         (local_be),
    .local_read_req   (local_read_req),
    .local_write_req  (local_write_req),
    .local_size       (local_size),
    .local_burst_begin(local_burst_begin),
    .local_wdata      (local_wdata),
    .ready_throttle   (ready_throttle),
    .local_ready      (local_ready),
    .local_wdata_req  (local_wdata_req),
    .local_rdata      (local_rdata),
    .local_rdata_valid(local_rdata_valid),
    .local_init_done  (local_init_done),
    .protocol_error   (protocol_error)
  );

  always #5 local_clk = ~local_clk;
  always @(posedge local_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Read-return monitor: every valid beat must match the oldest expectation on its due cycle.
  always @(negedge local_clk) begin
    exp_t e;
    if (!reset) begin
      if (local_rdata_valid) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected_valid", local_rdata_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("rd_data", local_rdata, e.data);
          chk("rd_cycle", 160'(cyc), 160'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rd_missing", local_rdata_valid, 1'b1);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!local_ready && k < 200) begin
      @(negedge local_clk);
      k++;
    end
    if (!local_ready) chk("ready_timeout", local_ready, 1'b1);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 60) begin
      @(negedge local_clk);
      k++;
    end
    chk("drain_empty", 160'(sb.size()), 160'd0);
    repeat (3) @(negedge local_clk);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [1:0] drv_size, input int beats,
                          input logic [19:0] be, input logic [159:0] d0, input logic [159:0] d1,
                          input logic bb, input logic rd_too);
    wait_ready();
    local_addr        = 23'(addr);
    local_size        = drv_size;
    local_burst_begin = bb;
    local_write_req   = 1'b1;
    local_read_req    = rd_too;
    @(negedge local_clk);
    local_write_req   = 1'b0;
    local_read_req    = 1'b0;
    local_burst_begin = 1'b1;
    chk("wr_ready_low", local_ready, 1'b0);
    for (int i = 0; i < beats; i++) begin
      chk("wdata_req_on", local_wdata_req, 1'b1);
      @(negedge local_clk);
      local_wdata = (i == 0) ? d0 : d1;
      local_be    = be;
    end
    chk("wdata_req_off", local_wdata_req, 1'b0);
    @(negedge local_clk);
    local_wdata = '0;
    local_be    = '0;
  endtask

  task automatic do_read(input logic [7:0] addr, input int size,
                         input logic [159:0] x0, input logic [159:0] x1);
    wait_ready();
    local_addr     = 23'(addr);
    local_size     = 2'(size);
    local_read_req = 1'b1;
    sb.push_back('{data: x0, due: cyc + 4});
    if (size == 2) sb.push_back('{data: x1, due: cyc + 5});
    @(negedge local_clk);
    local_read_req = 1'b0;
    if (size == 2) chk("rdissue_ready_low", local_ready, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", local_ready, 1'b0);
    chk("rst_wdata_req", local_wdata_req, 1'b0);
    chk("rst_rdata_valid", local_rdata_valid, 1'b0);
    chk("rst_init_done", local_init_done, 1'b0);
    chk("rst_protocol_error", protocol_error, 1'b0);
    chk("rst_rdata", local_rdata, '0);
  endtask

  task automatic do_reset();
    int k = 0;
    @(negedge local_clk);
    reset = 1'b1;
    sb.delete();
    local_read_req  = 1'b0;
    local_write_req = 1'b0;
    @(negedge local_clk);
    chk_reset_vals();
    reset = 1'b0;
    while (!local_init_done && k < 100) begin
      @(negedge local_clk);
      k++;
    end
    chk("reinit_done", local_init_done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    bit saw;

    vt[0] = '{1'b1, 8'h10, 1, BE_ALL, D0, '0, '0, '0};
    vt[1] = '{1'b0, 8'h10, 1, '0, '0, '0, D0, '0};
    vt[2] = '{1'b1, 8'h05, 1, BE_ALL, ONES, '0, '0, '0};
    vt[3] = '{1'b1, 8'h05, 1, 20'h00001, '0, '0, '0, '0};
    vt[4] = '{1'b0, 8'h05, 1, '0, '0, '0, BE_EXP, '0};
    vt[5] = '{1'b1, 8'hff, 2, BE_ALL, DA, DB, '0, '0};
    vt[6] = '{1'b0, 8'hff, 2, '0, '0, '0, DA, DB};

    reset             = 1'b1;
    local_addr        = '0;
    local_be          = '0;
    local_read_req    = 1'b0;
    local_write_req   = 1'b0;
    local_size        = 2'd1;
    local_burst_begin = 1'b1;
    local_wdata       = '0;
    ready_throttle    = 1'b0;

    repeat (3) @(negedge local_clk);
    chk_reset_vals();

    // Init timing: done and ready exactly 64 edges after release.
    reset = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      @(negedge local_clk);
      if (local_ready || local_init_done) early = 1'b1;
    end
    chk("init_early", early, 1'b0);
    @(negedge local_clk);
    chk("init_done_at_64", local_init_done, 1'b1);
    chk("ready_at_64", local_ready, 1'b1);

    ready_throttle = 1'b1;
    #1 chk("throttle_ready_low", local_ready, 1'b0);
    ready_throttle = 1'b0;
    #1 chk("throttle_ready_high", local_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      if (vt[i].wr) do_write(vt[i].addr, 2'(vt[i].size), vt[i].size, vt[i].be,
                             vt[i].d0, vt[i].d1, 1'b1, 1'b0);
      else do_read(vt[i].addr, vt[i].size, vt[i].x0, vt[i].x1);
    end
    drain();
    chk("no_error_clean_traffic", protocol_error, 1'b0);

    // Back-to-back single-beat reads across the wrap point.
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      local_addr     = (i % 2 == 0) ? 23'h0000ff : 23'h000000;
      local_size     = 2'd1;
      local_read_req = 1'b1;
      sb.push_back('{data: (i % 2 == 0) ? DA : DB, due: cyc + 4});
      @(negedge local_clk);
    end
    local_read_req = 1'b0;
    drain();

    // Reset with two read beats in flight.
    wait_ready();
    local_addr     = 23'h0000ff;
    local_size     = 2'd2;
    local_read_req = 1'b1;
    @(negedge local_clk);
    local_read_req = 1'b0;
    @(negedge local_clk);
    reset = 1'b1;
    sb.delete();
    #1 chk("flush_valid_in_reset", local_rdata_valid, 1'b0);
    @(negedge local_clk);
    reset = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge local_clk);
      if (local_rdata_valid) saw = 1'b1;
    end
    chk("flush_no_valid", saw, 1'b0);
    chk("flush_reinit", local_init_done, 1'b1);
    do_read(8'h10, 1, D0, '0);
    do_read(8'hff, 2, DA, DB);
    drain();

    // Simultaneous read and write: only the write is served.
    do_write(8'h20, 2'd1, 1, BE_ALL, DC, '0, 1'b1, 1'b1);
    repeat (8) @(negedge local_clk);
    chk("perr_rd_wr", protocol_error, 1'b1);
    do_read(8'h20, 1, DC, '0);
    drain();
    chk("perr_sticky", protocol_error, 1'b1);

    // Size 0 is served as one beat.
    do_reset();
    do_write(8'h21, 2'd0, 1, BE_ALL, DE, '0, 1'b1, 1'b0);
    chk("perr_size0", protocol_error, 1'b1);
    do_read(8'h21, 1, DE, '0);
    drain();

    // Missing burst_begin is flagged but the write still lands.
    do_reset();
    do_write(8'h22, 2'd1, 1, BE_ALL, DF, '0, 1'b0, 1'b0);
    chk("perr_burst_begin", protocol_error, 1'b1);
    do_read(8'h22, 1, DF, '0);
    drain();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
